mem_wb_pipe_reg: RTL
====================

Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM->WB pipeline register, the successor to the plain MEM-stage latch.
- Adds a valid/ready handshake so SRAM wait states can back-pressure the pipeline.
- Adds an optional 2-entry skid buffer so in_ready is a registered signal, plus a flush that inserts a bubble.
- Also provides a saturating back-pressure (stall) counter for performance debug.
- Sits between the MEM stage (SRAM controller side) and the WB stage / register-file write port.

Parameters:
- DATA_W, 32, width of ALU_result, MEM_read_value, PC and Instruction.
- DEST_W, 4, width of the destination register index.
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/exception bubble).
- in_valid  in  1  MEM stage presents a valid bundle.
- in_ready  out  1  block can accept a bundle this cycle.
- WB_en_in, MEM_R_en_in  in  1 each  control bits.
- ALU_result_in, MEM_read_value_in, PC_in, Instruction_in  in  DATA_W each  payload.
- Dest_in  in  DEST_W  destination register index.
- out_valid  out  1  WB stage bundle is valid.
- out_ready  in  1  WB stage consumes the bundle this cycle.
- WB_en, MEM_R_en  out  1 each  control outputs.
- ALU_result, MEM_read_value, PC, Instruction  out  DATA_W each  payload outputs.
- Dest  out  DEST_W  destination output.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset: rst is synchronous and active-high on clk. When rst=1 at a rising edge:
  - state becomes EMPTY.
  - All payload outputs, Dest, WB_en, MEM_R_en, out_valid and stall_cnt become 0.
  - The skid entry is cleared.
  - Inputs are ignored that cycle.
  - rst overrides flush and all handshakes, including mid-transfer.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: an accepted bundle appears on the outputs exactly 1 cycle later when the block was EMPTY, or was FULL and drained in the same cycle.
- Bundle integrity: the output bundle is always a complete copy of one accepted input bundle. Fields are never mixed between bundles.
- SKID_EN=1, states EMPTY / FULL / SKID. in_ready = (state != SKID) and depends only on registered state.
  - EMPTY: accept -> FULL, main <= input.
  - FULL, accept & drain -> FULL, main <= input.
  - FULL, accept & !drain -> SKID, skid <= input, main held.
  - FULL, !accept & drain -> EMPTY.
  - FULL, neither -> hold.
  - SKID: drain -> FULL, main <= skid. No drain -> hold. No accept is possible in SKID.
- SKID_EN=0, states EMPTY / FULL:
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions are the same as SKID_EN=1, but the accept & !drain case cannot occur.
- Ordering: strict FIFO order. The skid entry never bypasses main.
- out_valid = (state != EMPTY).
- Control gating: whenever out_valid=0, WB_en and MEM_R_en outputs are 0. Payload outputs hold their last value (don't care).
- Flush:
  - Next state is EMPTY. Both entries are invalidated and their control bits cleared.
  - An accept in the flush cycle is dropped (flush wins).
  - A drain in the flush cycle still counts as consumed by WB that cycle.
  - in_ready after flush is 1.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Back-pressure holding: outputs are stable (all fields unchanged) while out_valid & !out_ready.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 and ALU_result_in=32'hDEAD. Require out_valid=0, WB_en=0, all outputs 0, stall_cnt=0. After release, in_ready=1.
2. Streaming: out_ready=1, send bundles PC=4,8,12 (WB_en=1, Dest=3,5,7) on consecutive cycles. Require outputs PC=4,8,12 on the next three cycles, out_valid=1 throughout, stall_cnt=0.
3. Skid fill/drain, SKID_EN=1:
   - out_ready=0, send PC=4 then PC=8. Require in_ready=0 after the second accept, output PC=4 held, stall_cnt=1 then incrementing by 1 per cycle.
   - Raise out_ready. Require PC=4 then PC=8 in order, then EMPTY and in_ready=1.
4. Flush mid-occupancy: state SKID (PC=4, 8) plus flush=1 and in_valid=1 with PC=12. Next cycle require out_valid=0, WB_en=0, MEM_R_en=0, in_ready=1, and PC=12 never appearing on the outputs.
5. Saturation: CNT_W=4, out_ready=0 with one valid entry for 20 cycles. Require stall_cnt to stop at 15. Then assert rst and require stall_cnt=0.
6. SKID_EN=0 simultaneous events: FULL, out_ready=1, in_valid=1 with PC=16. Require in_ready=1 in the same cycle, output PC=16 next cycle. With out_ready=0, require in_ready=0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), flush-to-bubble and a saturating stall counter.
module mem_wb_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 4,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_en_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] MEM_read_value_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Instruction_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] MEM_read_value,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] Instruction,
  output logic [DEST_W-1:0] Dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int BW = 2 + 4 * DATA_W + DEST_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a bundle moves on a rising edge when valid and ready are both
  // high in the preceding cycle; accept = in_valid & in_ready,
  // drain = out_valid & out_ready. Neither valid depends on the other side's ready.
  state_t        state;
  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;
  logic          main_wb;
  logic          main_mr;
  logic          accept;
  logic          drain;

  assign in_bundle = {WB_en_in, MEM_R_en_in, ALU_result_in, MEM_read_value_in,
                      PC_in, Instruction_in, Dest_in};

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      assign in_ready = (state != SKID);
    end else begin : g_comb_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Payload is left in place; only the control bits are cleared.
      state              <= EMPTY;
      main_q[BW-1 -: 2]  <= 2'b00;
      skid_q[BW-1 -: 2]  <= 2'b00;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_bundle;
            state  <= FULL;
          end
        end
        FULL: begin
          if (accept && drain) begin
            main_q <= in_bundle;
          end else if (accept) begin
            skid_q <= in_bundle;
            state  <= SKID;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (drain) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign {main_wb, main_mr, ALU_result, MEM_read_value, PC, Instruction, Dest} = main_q;
  assign WB_en    = main_wb & out_valid;
  assign MEM_R_en = main_mr & out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
